rf_wb_sched: RTL and testbench
==============================

Name: rf_wb_sched

Overview:
- Writeback scheduler and scoreboard for the 8x16b bypassed register file.
- Shares the single RF write port between two writeback requesters: A (ALU result) and M (memory load return).
- Uses round-robin arbitration and drives the registered write port (writeEn/writeRegSel/writeData).
- Tracks per-register pending writes from the issue stage and flags read hazards that the write-before-read bypass cannot cover.

Parameters:
- NUM_REGS, 8, number of architectural registers.
- REG_W, 3, register select width (log2 NUM_REGS).
- DATA_W, 16, writeback data width.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- iss_valid  in  1  issue stage allocates a destination register this cycle.
- iss_reg  in  REG_W  destination register being allocated.
- a_valid  in  1  requester A has a writeback.
- a_reg  in  REG_W  requester A destination.
- a_data  in  DATA_W  requester A data.
- a_ready  out  1  A accepted this cycle (combinational).
- m_valid  in  1  requester M has a writeback.
- m_reg  in  REG_W  requester M destination.
- m_data  in  DATA_W  requester M data.
- m_ready  out  1  M accepted this cycle (combinational).
- writeEn  out  1  RF write enable (registered).
- writeRegSel  out  REG_W  RF write select (registered).
- writeData  out  DATA_W  RF write data (registered).
- read1RegSel  in  REG_W  decode read port 1 select.
- read2RegSel  in  REG_W  decode read port 2 select.
- hazard1  out  1  read port 1 needs to stall.
- hazard2  out  1  read port 2 needs to stall.
- pend_cnt  out  REG_W+1  number of registers pending.
- err  out  1  sticky protocol error.

Behaviour:
- Reset (async, rst_n low):
  - writeEn=0, writeRegSel=0, writeData=0.
  - pending[]=0, pend_cnt=0, err=0.
  - rr_ptr=A (A wins the first contention).
  - a_ready and m_ready follow the arbitration rules combinationally.
- Reset asserted mid-operation drops any accepted-but-unwritten writeback; no partial write occurs.
- Arbitration (combinational):
  - One grant per cycle.
  - Only one requester valid: it is granted.
  - Both valid: rr_ptr side is granted.
  - a_ready = grant_A; m_ready = grant_M.
  - Requesters hold valid/reg/data stable until ready.
- rr_ptr flips to the loser only on a contended cycle; uncontested grants leave it unchanged. This guarantees alternation under continuous contention.
- Write port latency: 1 cycle. A grant in cycle N gives writeEn=1 with the granted reg/data in cycle N+1. No grant in N gives writeEn=0 in N+1; sel/data hold their last value.
- Scoreboard, per register r, each cycle:
  - set = iss_valid && iss_reg==r.
  - clr = writeEn && writeRegSel==r.
  - next pending[r] = set ? 1 : (clr ? 0 : pending[r]). Set wins over a simultaneous clear, because a new producer was allocated.
- pend_cnt is the registered population count of pending[]. Range 0..NUM_REGS, no wrap.
- Hazards (combinational):
  - hazard1 = pending[read1RegSel] && !(writeEn && writeRegSel==read1RegSel).
  - hazard2 likewise for read port 2.
  - The RF bypass supplies same-cycle written data, so that case is not a hazard.
- Errors (err set next cycle, held until reset):
  - iss_valid to a register already pending and not being cleared that cycle (WAW).
  - writeEn to a register not pending.
  - A and M both valid with the same register in the same cycle.
- Errors do not alter arbitration or the write port.

Decomposition:
- Shared package: REG_W, DATA_W, NUM_REGS constants; requester enum {REQ_A=0, REQ_M=1}.
- One natural sub-module, rf_scoreboard: pending[], pend_cnt, hazard1/2, and the scoreboard error terms.
- Arbiter and write-port registers stay in the top.

Test Plan:
- Reset then idle: after rst_n rises, writeEn=0, pend_cnt=0, hazard1=hazard2=0, err=0.
- Issue r3, then A writes r3=0x1234: a_ready=1 in cycle N; in N+1 writeEn=1, writeRegSel=3, writeData=0x1234, and pending[3] clears in N+2.
  - With read1RegSel=3: hazard1=1 before N+1 and hazard1=0 in N+1 (bypass).
  - pend_cnt goes 1 -> 0.
- Issue r1 and r2; A(r1=0xAAAA) and M(r2=0x5555) valid together for 2 cycles:
  - Cycle 0 grants A, cycle 1 grants M.
  - Write port shows r1/0xAAAA then r2/0x5555.
  - Next contention grants A again.
- Issue r5 in the same cycle writeEn retires r5: pending[5] stays 1, pend_cnt unchanged, err=0.
- Error injection:
  - Issue r4 twice without a write: err=1 the following cycle and stays high.
  - Separately, after reset, M writes non-pending r6: err=1.
- Assert rst_n low while a grant is pending (cycle N): writeEn=0 immediately (async), pending[] cleared, and no write appears after release.

Source files
------------

// File: rtl/rf_wb_sched_pkg.sv
// Shared constants, requester encoding and popcount helper for the RF writeback scheduler.
// Pure declarations: no latency, no flow control.
package rf_wb_sched_pkg;

  localparam int NUM_REGS = 8;
  localparam int REG_W    = 3;
  localparam int DATA_W   = 16;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_M = 1'b1
  } req_e;

  function automatic logic [REG_W:0] popcnt(input logic [NUM_REGS-1:0] v);
    logic [REG_W:0] c;
    c = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      c = c + (REG_W+1)'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/rf_wb_sched_if.sv
// Writeback requester handshakes (A, M) plus the registered RF write port.
// Valid/ready: requesters hold reg/data stable until ready; the write port has no backpressure.
interface rf_wb_sched_if;
  import rf_wb_sched_pkg::*;

  logic              a_valid;
  logic [REG_W-1:0]  a_reg;
  logic [DATA_W-1:0] a_data;
  logic              a_ready;

  logic              m_valid;
  logic [REG_W-1:0]  m_reg;
  logic [DATA_W-1:0] m_data;
  logic              m_ready;

  logic              writeEn;
  logic [REG_W-1:0]  writeRegSel;
  logic [DATA_W-1:0] writeData;

  modport master (
    output a_valid, a_reg, a_data, input a_ready,
    output m_valid, m_reg, m_data, input m_ready,
    input  writeEn, writeRegSel, writeData
  );

  modport slave (
    input  a_valid, a_reg, a_data, output a_ready,
    input  m_valid, m_reg, m_data, output m_ready,
    output writeEn, writeRegSel, writeData
  );

endinterface

// File: rtl/rf_wb_sched_scoreboard.sv
// Per-register pending scoreboard: registered pending[]/pend_cnt, combinational hazards and error terms.
// Pending updates 1 cycle after issue/write; never stalls, only reports hazards to decode.
module rf_scoreboard
  import rf_wb_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             iss_valid,
  input  logic [REG_W-1:0] iss_reg,
  input  logic             writeEn,
  input  logic [REG_W-1:0] writeRegSel,
  input  logic [REG_W-1:0] read1RegSel,
  input  logic [REG_W-1:0] read2RegSel,
  output logic             hazard1,
  output logic             hazard2,
  output logic [REG_W:0]   pend_cnt,
  output logic             err_waw,
  output logic             err_nopend
);

  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_nxt;

  // A new allocation beats a same-cycle retire: the fresh producer is still outstanding.
  always_comb begin
    pending_nxt = pending;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (iss_valid && iss_reg == REG_W'(r))
        pending_nxt[r] = 1'b1;
      else if (writeEn && writeRegSel == REG_W'(r))
        pending_nxt[r] = 1'b0;
    end
  end

  // Data being written this cycle reaches decode through the RF bypass.
  assign hazard1 = pending[read1RegSel] && !(writeEn && writeRegSel == read1RegSel);
  assign hazard2 = pending[read2RegSel] && !(writeEn && writeRegSel == read2RegSel);

  assign err_waw    = iss_valid && pending[iss_reg] && !(writeEn && writeRegSel == iss_reg);
  assign err_nopend = writeEn && !pending[writeRegSel];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= '0;
      pend_cnt <= '0;
    end else begin
      pending  <= pending_nxt;
      pend_cnt <= popcnt(pending_nxt);
    end
  end

endmodule

// File: rtl/rf_wb_sched.sv
// Round-robin writeback arbiter (A vs M) driving the registered RF write port, plus scoreboard and sticky err.
// Grant to writeEn is 1 cycle; losers are held off via ready until their turn.
module rf_wb_sched
  import rf_wb_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             iss_valid,
  input  logic [REG_W-1:0] iss_reg,
  rf_wb_sched_if.slave     wb,
  input  logic [REG_W-1:0] read1RegSel,
  input  logic [REG_W-1:0] read2RegSel,
  output logic             hazard1,
  output logic             hazard2,
  output logic [REG_W:0]   pend_cnt,
  output logic             err
);

  req_e rr_ptr;
  logic contend;
  logic gnt_a;
  logic gnt_m;
  logic err_waw;
  logic err_nopend;
  logic err_same;

  assign contend  = wb.a_valid && wb.m_valid;
  assign gnt_a    = wb.a_valid && (!wb.m_valid || rr_ptr == REQ_A);
  assign gnt_m    = wb.m_valid && (!wb.a_valid || rr_ptr == REQ_M);
  assign wb.a_ready = gnt_a;
  assign wb.m_ready = gnt_m;
  assign err_same = contend && (wb.a_reg == wb.m_reg);

  // Pointer only moves on contention, so an idle or solo requester cannot steal the other's turn.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr         <= REQ_A;
      wb.writeEn     <= 1'b0;
      wb.writeRegSel <= '0;
      wb.writeData   <= '0;
      err            <= 1'b0;
    end else begin
      if (contend)
        rr_ptr <= gnt_a ? REQ_M : REQ_A;
      wb.writeEn <= gnt_a || gnt_m;
      if (gnt_a) begin
        wb.writeRegSel <= wb.a_reg;
        wb.writeData   <= wb.a_data;
      end else if (gnt_m) begin
        wb.writeRegSel <= wb.m_reg;
        wb.writeData   <= wb.m_data;
      end
      err <= err || err_waw || err_nopend || err_same;
    end
  end

  rf_scoreboard u_sb (
    .clk         (clk),
    .rst_n       (rst_n),
    .iss_valid   (iss_valid),
    .iss_reg     (iss_reg),
    .writeEn     (wb.writeEn),
    .writeRegSel (wb.writeRegSel),
    .read1RegSel (read1RegSel),
    .read2RegSel (read2RegSel),
    .hazard1     (hazard1),
    .hazard2     (hazard2),
    .pend_cnt    (pend_cnt),
    .err_waw     (err_waw),
    .err_nopend  (err_nopend)
  );

endmodule

// File: tb/tb_rf_wb_sched.sv
// Directed plus randomized bench for rf_wb_sched against a cycle-level reference model.
module tb_rf_wb_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       iss_valid = 1'b0;
  logic [2:0] iss_reg = '0;
  logic [2:0] read1RegSel = '0;
  logic [2:0] read2RegSel = '0;
  logic       hazard1;
  logic       hazard2;
  logic [3:0] pend_cnt;
  logic       err;

  rf_wb_sched_if wb ();

  rf_wb_sched dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .iss_valid   (iss_valid),
    .iss_reg     (iss_reg),
    .wb          (wb),
    .read1RegSel (read1RegSel),
    .read2RegSel (read2RegSel),
    .hazard1     (hazard1),
    .hazard2     (hazard2),
    .pend_cnt    (pend_cnt),
    .err         (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit     mp [8];
  bit     m_we;
  int     m_sel;
  int     m_data;
  bit     m_err;
  bit     m_prio_m;   // 1: M wins the next contention
  bit     last_ga;
  bit     last_gm;

  // Observed values at the last negedge
  logic       s_ar, s_mr, s_we, s_h1, s_h2, s_err;
  logic [2:0] s_sel;
  logic [15:0] s_data;
  logic [3:0] s_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 8; r++) mp[r] = 1'b0;
    m_we = 0; m_sel = 0; m_data = 0; m_err = 0;
    m_prio_m = 0; last_ga = 0; last_gm = 0;
  endtask

  task automatic clear_inputs();
    iss_valid = 0; iss_reg = '0;
    wb.a_valid = 0; wb.a_reg = '0; wb.a_data = '0;
    wb.m_valid = 0; wb.m_reg = '0; wb.m_data = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One clock: check outputs at negedge against the model, then advance the model at posedge.
  task automatic step();
    bit ga, gm, h1, h2, e;
    bit np [8];
    int cnt;
    @(negedge clk);
    ga = wb.a_valid && (!wb.m_valid || !m_prio_m);
    gm = wb.m_valid && (!wb.a_valid || m_prio_m);
    cnt = 0;
    for (int r = 0; r < 8; r++) cnt += int'(mp[r]);
    h1 = mp[read1RegSel] && !(m_we && m_sel == int'(read1RegSel));
    h2 = mp[read2RegSel] && !(m_we && m_sel == int'(read2RegSel));
    s_ar = wb.a_ready; s_mr = wb.m_ready; s_we = wb.writeEn; s_sel = wb.writeRegSel;
    s_data = wb.writeData; s_h1 = hazard1; s_h2 = hazard2; s_cnt = pend_cnt; s_err = err;
    chk("a_ready", 32'(s_ar), 32'(ga));
    chk("m_ready", 32'(s_mr), 32'(gm));
    chk("writeEn", 32'(s_we), 32'(m_we));
    chk("writeRegSel", 32'(s_sel), 32'(m_sel));
    chk("writeData", 32'(s_data), 32'(m_data));
    chk("hazard1", 32'(s_h1), 32'(h1));
    chk("hazard2", 32'(s_h2), 32'(h2));
    chk("pend_cnt", 32'(s_cnt), 32'(cnt));
    chk("err", 32'(s_err), 32'(m_err));
    for (int r = 0; r < 8; r++) begin
      if (iss_valid && int'(iss_reg) == r) np[r] = 1'b1;
      else if (m_we && m_sel == r) np[r] = 1'b0;
      else np[r] = mp[r];
    end
    e = (iss_valid && mp[iss_reg] && !(m_we && m_sel == int'(iss_reg)))
      || (m_we && !mp[m_sel])
      || (wb.a_valid && wb.m_valid && wb.a_reg == wb.m_reg);
    @(posedge clk);
    for (int r = 0; r < 8; r++) mp[r] = np[r];
    m_err = m_err || e;
    if (wb.a_valid && wb.m_valid) m_prio_m = ga;
    m_we = ga || gm;
    if (ga) begin m_sel = int'(wb.a_reg); m_data = int'(wb.a_data); end
    else if (gm) begin m_sel = int'(wb.m_reg); m_data = int'(wb.m_data); end
    last_ga = ga; last_gm = gm;
    #1;
  endtask

  task automatic issue(input logic [2:0] r);
    iss_valid = 1; iss_reg = r;
    step();
    iss_valid = 0;
  endtask

  initial begin
    clear_inputs();
    model_reset();
    // Reset then idle
    do_reset();
    step();
    chk("rst_we", 32'(s_we), 32'd0);
    chk("rst_cnt", 32'(s_cnt), 32'd0);
    chk("rst_haz", 32'({s_h1, s_h2}), 32'd0);
    chk("rst_err", 32'(s_err), 32'd0);

    // Issue r3, A writes r3=0x1234, bypass clears hazard in the write cycle
    read1RegSel = 3'd3;
    issue(3'd3);
    step();
    chk("t2_haz_pre", 32'(s_h1), 32'd1);
    chk("t2_cnt1", 32'(s_cnt), 32'd1);
    wb.a_valid = 1; wb.a_reg = 3'd3; wb.a_data = 16'h1234;
    step();
    chk("t2_a_ready", 32'(s_ar), 32'd1);
    wb.a_valid = 0;
    step();
    chk("t2_we", 32'(s_we), 32'd1);
    chk("t2_sel", 32'(s_sel), 32'd3);
    chk("t2_data", 32'(s_data), 32'h1234);
    chk("t2_bypass", 32'(s_h1), 32'd0);
    step();
    chk("t2_cnt0", 32'(s_cnt), 32'd0);

    // Round-robin under contention
    issue(3'd1); issue(3'd2); issue(3'd7); issue(3'd0);
    wb.a_valid = 1; wb.a_reg = 3'd1; wb.a_data = 16'hAAAA;
    wb.m_valid = 1; wb.m_reg = 3'd2; wb.m_data = 16'h5555;
    step();
    chk("rr_c0_a", 32'({s_ar, s_mr}), 32'b10);
    wb.a_reg = 3'd7; wb.a_data = 16'h7777;
    step();
    chk("rr_c1_m", 32'({s_ar, s_mr}), 32'b01);
    chk("rr_wr1", 32'({s_sel, s_data}), {13'd0, 3'd1, 16'hAAAA});
    wb.m_reg = 3'd0; wb.m_data = 16'h0F0F;
    step();
    chk("rr_c2_a", 32'({s_ar, s_mr}), 32'b10);
    chk("rr_wr2", 32'({s_sel, s_data}), {13'd0, 3'd2, 16'h5555});
    wb.a_valid = 0;
    step();
    wb.m_valid = 0;
    step();
    step();
    chk("rr_cnt0", 32'(s_cnt), 32'd0);

    // Issue r5 in the same cycle the write port retires r5
    issue(3'd5);
    wb.a_valid = 1; wb.a_reg = 3'd5; wb.a_data = 16'hBEEF;
    step();
    wb.a_valid = 0;
    iss_valid = 1; iss_reg = 3'd5;
    step();
    chk("t4_we5", 32'({s_we, s_sel}), {28'd0, 1'b1, 3'd5});
    iss_valid = 0;
    step();
    chk("t4_cnt", 32'(s_cnt), 32'd1);
    chk("t4_err", 32'(s_err), 32'd0);

    // WAW error is sticky
    issue(3'd4); issue(3'd4);
    step();
    chk("waw_err", 32'(s_err), 32'd1);
    step();
    chk("waw_sticky", 32'(s_err), 32'd1);

    // M writes a non-pending register
    do_reset();
    wb.m_valid = 1; wb.m_reg = 3'd6; wb.m_data = 16'h0066;
    step();
    wb.m_valid = 0;
    step();
    chk("np_err_pre", 32'(s_err), 32'd0);
    step();
    chk("np_err", 32'(s_err), 32'd1);

    // Async reset with writes in flight
    do_reset();
    issue(3'd2); issue(3'd3);
    wb.a_valid = 1; wb.a_reg = 3'd2; wb.a_data = 16'h2222;
    step();
    wb.a_valid = 0;
    wb.m_valid = 1; wb.m_reg = 3'd3; wb.m_data = 16'h3333;
    @(negedge clk);
    chk("ar_we_before", 32'(wb.writeEn), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_we_async", 32'(wb.writeEn), 32'd0);
    chk("ar_cnt_async", 32'(pend_cnt), 32'd0);
    clear_inputs();
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    chk("ar_no_write", 32'(s_we), 32'd0);
    step();

    // Randomized traffic with periodic resets
    for (int i = 0; i < 600; i++) begin
      if (i % 64 == 0) do_reset();
      if (!(wb.a_valid && !last_ga)) begin
        wb.a_valid = 1'($urandom_range(0, 1));
        wb.a_reg = 3'($urandom_range(0, 7));
        wb.a_data = 16'($urandom);
      end
      if (!(wb.m_valid && !last_gm)) begin
        wb.m_valid = 1'($urandom_range(0, 1));
        wb.m_reg = 3'($urandom_range(0, 7));
        wb.m_data = 16'($urandom);
      end
      iss_valid = ($urandom_range(0, 2) == 0);
      iss_reg = 3'($urandom_range(0, 7));
      read1RegSel = 3'($urandom_range(0, 7));
      read2RegSel = 3'($urandom_range(0, 7));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
